change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy $5/$2/$1 change dispenser FSM driving coin hoppers
// Optional ack timeout enabled by defining CHANGE_ACK_TIMEOUT_EN.
module change_dispenser #(
   parameter int PULSE_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [7:0] req_amount,
   output logic       req_ready,
   input  logic [2:0] hop_empty,
   output logic [2:0] hop_fire,
   input  logic       hop_ack,
   output logic [7:0] remaining,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] fault_code
);

   typedef enum logic [2:0] {IDLE, SELECT, FIRE, WAIT_ACK, DONE, FAULT} state_t;

   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

   if (PULSE_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
      $error("change_dispenser: PULSE_CYCLES and ACK_TIMEOUT must be at least 1");
   end

   state_t        state, state_next;
   logic [7:0]    rem_next;
   logic [1:0]    code_next;
   logic [2:0]    sel, sel_next;
   logic [PW-1:0] pulse_cnt, pulse_next;
   logic [2:0]    d_val;

`ifdef CHANGE_ACK_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
   logic [TW-1:0] to_cnt, to_next;
`endif

   // sel is one-hot in hop_fire bit order; d_val is its dollar value
   assign d_val     = sel[2] ? 3'd5 : (sel[1] ? 3'd2 : 3'd1);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign fault     = (state == FAULT);
   assign hop_fire  = (state == FIRE) ? sel : 3'b000;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         remaining  <= '0;
         fault_code <= '0;
         sel        <= '0;
         pulse_cnt  <= '0;
`ifdef CHANGE_ACK_TIMEOUT_EN
         to_cnt     <= '0;
`endif
      end else begin
         state      <= state_next;
         remaining  <= rem_next;
         fault_code <= code_next;
         sel        <= sel_next;
         pulse_cnt  <= pulse_next;
`ifdef CHANGE_ACK_TIMEOUT_EN
         to_cnt     <= to_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      rem_next   = remaining;
      code_next  = fault_code;
      sel_next   = sel;
      pulse_next = pulse_cnt;
`ifdef CHANGE_ACK_TIMEOUT_EN
      to_next    = to_cnt;
`endif
      case (state)
         IDLE: begin
            if (req_valid) begin
               rem_next   = req_amount;
               code_next  = 2'd0;
               state_next = SELECT;
            end
         end
         SELECT: begin
            pulse_next = '0;
            // greedy pick, no backtracking: a dead end faults with the unpaid amount
            if (remaining == 8'd0) begin
               state_next = DONE;
            end else if (remaining >= 8'd5 && !hop_empty[2]) begin
               sel_next   = 3'b100;
               state_next = FIRE;
            end else if (remaining >= 8'd2 && !hop_empty[1]) begin
               sel_next   = 3'b010;
               state_next = FIRE;
            end else if (!hop_empty[0]) begin
               sel_next   = 3'b001;
               state_next = FIRE;
            end else begin
               code_next  = 2'd1;
               state_next = FAULT;
            end
         end
         FIRE: begin
            if (pulse_cnt == PULSE_LAST) begin
               pulse_next = '0;
               state_next = WAIT_ACK;
`ifdef CHANGE_ACK_TIMEOUT_EN
               to_next    = '0;
`endif
            end else begin
               pulse_next = pulse_cnt + 1'b1;
            end
         end
         WAIT_ACK: begin
            if (hop_ack) begin
               rem_next   = remaining - {5'd0, d_val};
               state_next = SELECT;
            end
`ifdef CHANGE_ACK_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
               code_next  = 2'd2;
               state_next = FAULT;
            end else begin
               to_next = to_cnt + 1'b1;
            end
`endif
         end
         DONE:    state_next = IDLE;
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule
